serial_adder_ctrl: RTL and testbench

Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It time-multiplexes a single existing `full_adder` cell over WIDTH cycles, LSB first, and returns sum, carry-out and signed overflow over a second valid/ready handshake. It is the sequencing layer for the 1-bit adder datapath in the arithmetic-logic group, and the area-minimal alternative to a ripple-carry array.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width; at least one bit so the counter is always a real vector.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder reused over WIDTH cycles, LSB first,
// with valid/ready handshakes on operand input and result output.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output state_e           dbg_state
);

    localparam int CNT_W = cnt_width(WIDTH);

    // Handshake rule: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready combinationally on either side.

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cmsb_q, cmsb_d;
    logic               cout_q, cout_d;
    logic               fa_s, fa_cout;
    logic               last_bit;

    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_d    = {fa_s, sh_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                // Published result only changes here, so it persists through IDLE.
                if (last_bit) begin
                    cmsb_d  = carry_q;
                    sum_d   = {fa_s, sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    cnt_d   = cnt_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = cmsb_q ^ cout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;
    import serial_adder_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    state_e       dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int acc_cyc;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Present operands for one edge; caller is 1ns after an edge with in_ready high.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if (sum !== 8'h00)      begin n_fail++; $display("FAIL reset_sum got=%h exp=00", sum); end
        n_cmp++; if (cout !== 1'b0 || ovf !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", cout, ovf); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int n;
        start_op(8'h03, 8'h05, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got=%b exp=1", busy); end
        wait_done(n);
        n_cmp++; if (n != W) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", n, W); end
        n_cmp++; if ({cout, ovf, sum} !== {1'b0, 1'b0, 8'h08}) begin n_fail++; $display("FAIL basic_result got=%b %b %h exp=0 0 08", cout, ovf, sum); end
        consume();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_return_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_table();
        // {a, b, cin, exp_sum, exp_cout, exp_ovf}
        logic [W-1:0] ta[3] = '{8'hFF, 8'h7F, 8'h80};
        logic [W-1:0] tb[3] = '{8'h00, 8'h01, 8'h80};
        logic         tc[3] = '{1'b1, 1'b0, 1'b0};
        logic [W-1:0] es[3] = '{8'h00, 8'h80, 8'h00};
        logic         ec[3] = '{1'b1, 1'b0, 1'b1};
        logic         eo[3] = '{1'b0, 1'b1, 1'b1};
        int n;
        for (int i = 0; i < 3; i++) begin
            start_op(ta[i], tb[i], tc[i]);
            wait_done(n);
            n_cmp++;
            if (n != W || sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
                n_fail++;
                $display("FAIL table_%0d got=n%0d %h c%b o%b exp=n%0d %h c%b o%b", i, n, sum, cout, ovf, W, es[i], ec[i], eo[i]);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int n;
        start_op(8'h12, 8'h34, 1'b0);
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        n = 0;
        while (!out_valid && n < 50) begin
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_run got=%b exp=0", in_ready); end
            @(posedge clk); #1;
            n++;
        end
        n_cmp++; if (n != W) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", n, W); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d got=v%b r%b %h c%b o%b exp=v1 r0 46 c0 o0", i, out_valid, in_ready, sum, cout, ovf);
            end
        end
        in_valid = 1'b0;
        consume();
        n_cmp++; if (in_ready !== 1'b1 || dbg_state !== IDLE) begin n_fail++; $display("FAIL bp_release got=r%b st%0d exp=r1 st0", in_ready, dbg_state); end
        n_cmp++; if (sum !== 8'h46) begin n_fail++; $display("FAIL bp_persist got=%h exp=46", sum); end
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset got=r%b v%b b%b %h exp=r1 v0 b0 00", in_ready, out_valid, busy, sum);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(n);
        n_cmp++; if (n != W || sum !== 8'h02 || cout !== 1'b0) begin n_fail++; $display("FAIL post_reset_op got=n%0d %h c%b exp=n8 02 c0", n, sum, cout); end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_q[$];
        logic [W:0]   full;
        logic [W-1:0] av, bv, es;
        logic         cv, eo;
        int n, prev_acc;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            av = W'($urandom_range(0, 255));
            bv = W'($urandom_range(0, 255));
            cv = 1'($urandom_range(0, 1));
            full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
            exp_q.push_back(full[W-1:0]);
            start_op(av, bv, cv);
            if (i > 0) begin
                n_cmp++; if (acc_cyc - prev_acc != W + 2) begin n_fail++; $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", i, acc_cyc - prev_acc, W + 2); end
            end
            prev_acc = acc_cyc;
            wait_done(n);
            es = exp_q.pop_front();
            eo = (av[W-1] == bv[W-1]) && (es[W-1] != av[W-1]);
            n_cmp++;
            if (n != W || sum !== es || cout !== full[W] || ovf !== eo) begin
                n_fail++;
                $display("FAIL b2b_result_%0d a=%h b=%h c=%b got=%h c%b o%b exp=%h c%b o%b", i, av, bv, cv, sum, cout, ovf, es, full[W], eo);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_table();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
